// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: shared definitions for the multi-cycle ALU.
// Holds the operation encodings, the FSM state type and the opcode group masks.
// The optional divider is selected with RV_ALU_MC_DIV_EN (see rv_alu_mc).
package rv_alu_pkg;

   typedef enum logic [4:0] {
      OpAdd    = 5'h00,
      OpSub    = 5'h01,
      OpSll    = 5'h02,
      OpSrl    = 5'h03,
      OpSra    = 5'h04,
      OpOr     = 5'h05,
      OpAnd    = 5'h06,
      OpXor    = 5'h07,
      OpEq     = 5'h08,
      OpUlt    = 5'h09,
      OpUgt    = 5'h0A,
      OpSlt    = 5'h0B,
      OpSge    = 5'h0C,
      OpMul    = 5'h10,
      OpMulh   = 5'h11,
      OpMulhsu = 5'h12,
      OpMulhu  = 5'h13,
      OpDiv    = 5'h14,
      OpDivu   = 5'h15,
      OpRem    = 5'h16,
      OpRemu   = 5'h17
   } op_sel_e;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv,
      StDone
   } state_e;

   // The top three opcode bits identify the multiply and divide groups.
   localparam logic [4:0] OpGrpMask = 5'b11100;
   localparam logic [4:0] OpGrpMul  = 5'b10000;
   localparam logic [4:0] OpGrpDiv  = 5'b10100;

   function automatic logic is_mul_op(logic [4:0] op);
      return (op & OpGrpMask) == OpGrpMul;
   endfunction

   function automatic logic is_div_op(logic [4:0] op);
      return (op & OpGrpMask) == OpGrpDiv;
   endfunction

   function automatic logic is_rem_op(logic [4:0] op);
      return (op == OpRem) || (op == OpRemu);
   endfunction

   // Operand A is treated as signed by MUL/MULH/MULHSU/DIV/REM.
   function automatic logic opa_signed(logic [4:0] op);
      return (op == OpMul) || (op == OpMulh) || (op == OpMulhsu) ||
             (op == OpDiv) || (op == OpRem);
   endfunction

   // Operand B is treated as signed by MUL/MULH/DIV/REM.
   function automatic logic opb_signed(logic [4:0] op);
      return (op == OpMul) || (op == OpMulh) || (op == OpDiv) || (op == OpRem);
   endfunction

endpackage

// File: rtl/rv_alu_core.sv
// rv_alu_core: combinational single-cycle base operations.
// Any encoding outside the base set (including M ops) yields zero.
module rv_alu_core
   import rv_alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] opr_a_i,
   input  logic [XLEN-1:0] opr_b_i,
   input  logic [4:0]      op_sel_i,
   output logic [XLEN-1:0] res_o
);

   localparam int unsigned ShW = $clog2(XLEN);

   logic [ShW-1:0] shamt;
   logic           flag;

   assign shamt = opr_b_i[ShW-1:0];

   // Decode the operation; compares return the flag zero-extended.
   always_comb begin
      res_o = '0;
      flag  = 1'b0;
      case (op_sel_i)
         OpAdd:   res_o = opr_a_i + opr_b_i;
         OpSub:   res_o = opr_a_i - opr_b_i;
         OpSll:   res_o = opr_a_i << shamt;
         OpSrl:   res_o = opr_a_i >> shamt;
         OpSra:   res_o = $signed(opr_a_i) >>> shamt;
         OpOr:    res_o = opr_a_i | opr_b_i;
         OpAnd:   res_o = opr_a_i & opr_b_i;
         OpXor:   res_o = opr_a_i ^ opr_b_i;
         OpEq: begin
            flag  = (opr_a_i == opr_b_i);
            res_o = {{(XLEN-1){1'b0}}, flag};
         end
         OpUlt: begin
            flag  = (opr_a_i < opr_b_i);
            res_o = {{(XLEN-1){1'b0}}, flag};
         end
         OpUgt: begin
            flag  = (opr_a_i > opr_b_i);
            res_o = {{(XLEN-1){1'b0}}, flag};
         end
         OpSlt: begin
            flag  = ($signed(opr_a_i) < $signed(opr_b_i));
            res_o = {{(XLEN-1){1'b0}}, flag};
         end
         OpSge: begin
            flag  = ($signed(opr_a_i) >= $signed(opr_b_i));
            res_o = {{(XLEN-1){1'b0}}, flag};
         end
         default: res_o = '0;
      endcase
   end

endmodule

// File: rtl/rv_alu_mc.sv
// rv_alu_mc: multi-cycle RV32I/M ALU with valid/ready handshake and registered result.
// Base ops finish in one cycle; multiply (and divide when RV_ALU_MC_DIV_EN is defined)
// iterate over XLEN cycles on operand magnitudes with a final sign fix-up.
// Without RV_ALU_MC_DIV_EN the divide/remainder ops return zero in one cycle.
module rv_alu_mc
   import rv_alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [XLEN-1:0] opr_a_i,
   input  logic [XLEN-1:0] opr_b_i,
   input  logic [4:0]      op_sel_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] alu_res_o,
   output logic            busy_o
);

   localparam int unsigned     CntW    = $clog2(XLEN) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

   state_e              state_q, state_d;
   logic [4:0]          op_q, op_d;
   logic [XLEN-1:0]     res_q, res_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]     mplr_q, mplr_d;
   logic [2*XLEN-1:0]   prod_q, prod_d;
   logic                neg_q, neg_d;

   logic [XLEN-1:0]     core_res;
   logic                accept;
   logic                neg_a, neg_b;
   logic [XLEN-1:0]     mag_a, mag_b;
   logic [2*XLEN-1:0]   mul_sum, mul_fix;

   rv_alu_core #(
      .XLEN (XLEN)
   ) u_core (
      .opr_a_i  (opr_a_i),
      .opr_b_i  (opr_b_i),
      .op_sel_i (op_sel_i),
      .res_o    (core_res)
   );

   assign in_ready_o  = (state_q == StIdle) | ((state_q == StDone) & out_ready_i);
   assign out_valid_o = (state_q == StDone);
   assign busy_o      = (state_q == StMul) | (state_q == StDiv);
   assign alu_res_o   = res_q;
   assign accept      = in_valid_i & in_ready_o;

   assign neg_a = opa_signed(op_sel_i) & opr_a_i[XLEN-1];
   assign neg_b = opb_signed(op_sel_i) & opr_b_i[XLEN-1];
   assign mag_a = neg_a ? -opr_a_i : opr_a_i;
   assign mag_b = neg_b ? -opr_b_i : opr_b_i;

   // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
   assign mul_sum = prod_q + (mplr_q[0] ? mcand_q : '0);
   assign mul_fix = neg_q ? -mul_sum : mul_sum;

`ifdef RV_ALU_MC_DIV_EN
   localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;

   logic [XLEN:0]   div_shift, div_diff;
   logic [XLEN-1:0] div_rem_nx, div_quo_nx, div_quo_fix, div_rem_fix;
   logic            div_zero, div_ovf;

   // Restoring step: bring in the next dividend bit, keep the difference if non-negative.
   assign div_shift   = {rem_q, quo_q[XLEN-1]};
   assign div_diff    = div_shift - {1'b0, dvs_q};
   assign div_rem_nx  = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
   assign div_quo_nx  = {quo_q[XLEN-2:0], ~div_diff[XLEN]};
   assign div_quo_fix = qneg_q ? -div_quo_nx : div_quo_nx;
   assign div_rem_fix = rneg_q ? -div_rem_nx : div_rem_nx;

   assign div_zero = (opr_b_i == '0);
   assign div_ovf  = ((op_sel_i == OpDiv) || (op_sel_i == OpRem)) &&
                     (opr_a_i == MinNeg) && (opr_b_i == '1);
`endif

   // Next-state, datapath capture and iteration control.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      prod_d  = prod_q;
      neg_d   = neg_q;
`ifdef RV_ALU_MC_DIV_EN
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            if ((state_q == StDone) && out_ready_i) begin
               state_d = StIdle;
            end
            if (accept) begin
               op_d  = op_sel_i;
               cnt_d = '0;
               if (is_mul_op(op_sel_i)) begin
                  state_d = StMul;
                  mcand_d = {{XLEN{1'b0}}, mag_a};
                  mplr_d  = mag_b;
                  prod_d  = '0;
                  neg_d   = neg_a ^ neg_b;
               end
`ifdef RV_ALU_MC_DIV_EN
               else if (is_div_op(op_sel_i)) begin
                  if (div_zero) begin
                     state_d = StDone;
                     res_d   = is_rem_op(op_sel_i) ? opr_a_i : '1;
                  end else if (div_ovf) begin
                     state_d = StDone;
                     res_d   = is_rem_op(op_sel_i) ? '0 : opr_a_i;
                  end else begin
                     state_d = StDiv;
                     rem_d   = '0;
                     quo_d   = mag_a;
                     dvs_d   = mag_b;
                     qneg_d  = neg_a ^ neg_b;
                     rneg_d  = neg_a;
                  end
               end
`endif
               else begin
                  state_d = StDone;
                  res_d   = core_res;
               end
            end
         end
         StMul: begin
            prod_d  = mul_sum;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               state_d = StDone;
               res_d   = (op_q == OpMul) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
            end
         end
`ifdef RV_ALU_MC_DIV_EN
         StDiv: begin
            rem_d = div_rem_nx;
            quo_d = div_quo_nx;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               state_d = StDone;
               res_d   = is_rem_op(op_q) ? div_rem_fix : div_quo_fix;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         prod_q  <= '0;
         neg_q   <= 1'b0;
`ifdef RV_ALU_MC_DIV_EN
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         prod_q  <= prod_d;
         neg_q   <= neg_d;
`ifdef RV_ALU_MC_DIV_EN
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

endmodule

// File: tb/tb_rv_alu_mc.sv
// tb_rv_alu_mc: scoreboard bench for rv_alu_mc (XLEN=32).
// Expected results come from an arithmetic reference model; RV_ALU_MC_DIV_EN selects
// whether divide/remainder are modelled as real division or as zero.
module tb_rv_alu_mc;
   import rv_alu_pkg::*;

   localparam int unsigned   XLEN   = 32;
   localparam logic [31:0]   MinNeg = 32'h8000_0000;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] opr_a_i;
   logic [31:0] opr_b_i;
   logic [4:0]  op_sel_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] alu_res_o;
   logic        busy_o;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   last_wait;
   bit   rand_bp  = 0;
   exp_t exp_q[$];

   rv_alu_mc #(
      .XLEN (XLEN)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .opr_a_i     (opr_a_i),
      .opr_b_i     (opr_b_i),
      .op_sel_i    (op_sel_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .alu_res_o   (alu_res_o),
      .busy_o      (busy_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] model_res(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      int          sa, sb;
      longint      p;
      logic [63:0] up;
      logic [31:0] r;
      sa = a;
      sb = b;
      r  = '0;
      case (op)
         OpAdd:    r = a + b;
         OpSub:    r = a - b;
         OpSll:    r = a << b[4:0];
         OpSrl:    r = a >> b[4:0];
         OpSra:    r = sa >>> b[4:0];
         OpOr:     r = a | b;
         OpAnd:    r = a & b;
         OpXor:    r = a ^ b;
         OpEq:     r = {31'b0, a == b};
         OpUlt:    r = {31'b0, a < b};
         OpUgt:    r = {31'b0, a > b};
         OpSlt:    r = {31'b0, sa < sb};
         OpSge:    r = {31'b0, sa >= sb};
         OpMul: begin
            p = longint'(sa) * longint'(sb);
            r = p[31:0];
         end
         OpMulh: begin
            p = longint'(sa) * longint'(sb);
            r = p[63:32];
         end
         OpMulhsu: begin
            p = longint'(sa) * longint'({32'b0, b});
            r = p[63:32];
         end
         OpMulhu: begin
            up = {32'b0, a} * {32'b0, b};
            r  = up[63:32];
         end
`ifdef RV_ALU_MC_DIV_EN
         OpDiv: begin
            if (b == 0) r = '1;
            else if (a == MinNeg && b == '1) r = MinNeg;
            else r = sa / sb;
         end
         OpDivu:   r = (b == 0) ? '1 : a / b;
         OpRem: begin
            if (b == 0) r = a;
            else if (a == MinNeg && b == '1) r = '0;
            else r = sa % sb;
         end
         OpRemu:   r = (b == 0) ? a : a % b;
`endif
         default:  r = '0;
      endcase
      return r;
   endfunction

   function automatic int model_lat(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
      if (op >= OpMul && op <= OpMulhu) return XLEN + 1;
`ifdef RV_ALU_MC_DIV_EN
      if (op >= OpDiv && op <= OpRemu) begin
         if (b == 0 || ((op == OpDiv || op == OpRem) && a == MinNeg && b == '1)) return 1;
         return XLEN + 1;
      end
`endif
      return 1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Present one op and wait (bounded) for acceptance; pushes the expectation on accept.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      int   waited;
      logic rdy;
      exp_t e;
      in_valid_i = 1'b1;
      op_sel_i   = op;
      opr_a_i    = a;
      opr_b_i    = b;
      waited     = 0;
      rdy        = 1'b0;
      while (!rdy && waited < 200) begin
         @(negedge clk);
         rdy = in_ready_o;
         @(posedge clk);
         #1;
         if (!rdy) begin
            waited++;
            if (rand_bp) out_ready_i = ($urandom_range(0, 2) != 0);
         end
      end
      in_valid_i = 1'b0;
      last_wait  = waited;
      check("accept_within_bound", {31'b0, rdy}, 32'd1);
      if (rdy) begin
         e.res = model_res(op, a, b);
         e.lat = model_lat(op, a, b);
         e.acc = cyc;
         exp_q.push_back(e);
      end
   endtask

   task automatic drain();
      int w;
      out_ready_i = 1'b1;
      w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("drain_queue_empty", exp_q.size(), 32'd0);
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return MinNeg;
         3:       return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   // Monitor: latency on first valid, hold behaviour, and result on each handshake.
   initial begin
      bit started   = 0;
      bit prev_hold = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            started   = 0;
            prev_hold = 0;
            continue;
         end
         if (prev_hold) check("valid_held_without_ready", {31'b0, out_valid_o}, 32'd1);
         if (out_valid_o) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: out_valid_o=1 res=%h with nothing outstanding",
                        alu_res_o);
            end else begin
               if (!started) begin
                  started = 1;
                  check("latency", cyc - exp_q[0].acc + 1, exp_q[0].lat);
               end
               if (prev_hold) check("result_stable_under_backpressure", alu_res_o,
                                    exp_q[0].res);
               if (out_ready_i) begin
                  check("result", alu_res_o, exp_q[0].res);
                  void'(exp_q.pop_front());
                  started = 0;
               end
            end
         end
         prev_hold = out_valid_o && !out_ready_i;
      end
   end

   initial begin
      int busy_cnt;
      int w;
      logic [31:0] hold_exp;

      reset       = 1'b1;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      op_sel_i    = '0;
      opr_a_i     = '0;
      opr_b_i     = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_out_valid", {31'b0, out_valid_o}, 32'd0);
      check("reset_alu_res", alu_res_o, 32'd0);
      check("reset_busy", {31'b0, busy_o}, 32'd0);
      check("reset_in_ready", {31'b0, in_ready_o}, 32'd1);
      @(posedge clk);
      #1;

      // Back-to-back base ops.
      out_ready_i = 1'b1;
      issue(OpAdd, 32'd5, 32'd7);
      issue(OpSra, 32'h8000_0000, 32'd4);
      check("back_to_back_no_wait", last_wait, 32'd0);

      // Multiply with busy window.
      issue(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      busy_cnt = 0;
      w = 0;
      while (w < 100) begin
         @(negedge clk);
         if (out_valid_o) break;
         if (busy_o) busy_cnt++;
         w++;
      end
      check("mul_busy_cycles", busy_cnt, XLEN);
      @(posedge clk);
      #1;
      issue(OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(OpMulh, 32'hFFFF_FFF9, 32'd3);
      issue(OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Division including divide-by-zero and signed overflow.
      issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
      issue(OpRem, 32'hFFFF_FFF9, 32'd2);
      issue(OpDivu, 32'd10, 32'd0);
      issue(OpRemu, 32'd10, 32'd0);
      issue(OpDiv, MinNeg, 32'hFFFF_FFFF);
      issue(OpRem, MinNeg, 32'hFFFF_FFFF);
      issue(OpDivu, 32'hFFFF_FFFF, 32'd7);
      issue(5'h0E, 32'd1, 32'd2);
      drain();

      // Backpressure: result held, new request refused, then accepted on release.
      out_ready_i = 1'b0;
      issue(OpXor, 32'hA5A5_0F0F, 32'h0FF0_1234);
      hold_exp   = model_res(OpXor, 32'hA5A5_0F0F, 32'h0FF0_1234);
      in_valid_i = 1'b1;
      op_sel_i   = OpOr;
      opr_a_i    = 32'h1200_0000;
      opr_b_i    = 32'h0000_0034;
      repeat (5) begin
         @(negedge clk);
         check("bp_out_valid", {31'b0, out_valid_o}, 32'd1);
         check("bp_alu_res", alu_res_o, hold_exp);
         check("bp_in_ready", {31'b0, in_ready_o}, 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready_i = 1'b1;
      issue(OpOr, 32'h1200_0000, 32'h0000_0034);
      check("bp_release_accept_same_cycle", last_wait, 32'd0);
      drain();

      // Reset in the middle of a multiply.
      issue(OpMul, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midreset_out_valid", {31'b0, out_valid_o}, 32'd0);
      check("midreset_busy", {31'b0, busy_o}, 32'd0);
      check("midreset_in_ready", {31'b0, in_ready_o}, 32'd1);
      repeat (40) @(negedge clk);
      @(posedge clk);
      #1;

      // Randomized ops with random backpressure.
      rand_bp = 1;
      for (int i = 0; i < 200; i++) begin
         logic [4:0] op;
         int         r;
         r = $urandom_range(0, 3);
         if (r < 2) op = 5'($urandom_range(0, 12));
         else if (r == 2) op = 5'(16 + $urandom_range(0, 7));
         else op = 5'($urandom_range(0, 31));
         out_ready_i = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
         end
         issue(op, rand_opnd(), rand_opnd());
      end
      rand_bp = 0;
      drain();
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
